// File: rtl/final_sysid_checker.sv
// Avalon-MM read master that fetches the system ID and build timestamp from the ID slave
// and reports whether both match the values baked in at build time.
module final_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd4919,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1498052167,
    parameter int unsigned TIMEOUT_CYCLES     = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] captured_id,
    output logic [31:0] captured_timestamp
);

    typedef enum logic [2:0] {
        StIdle,
        StRdIdReq,
        StRdIdWait,
        StRdTsReq,
        StRdTsWait,
        StDone
    } state_e;

    localparam logic [31:0] TimeoutLimit = 32'(TIMEOUT_CYCLES);

    state_e      state_q;
    logic [31:0] count_q;
    logic        count_expired;

    // True when the cycle now ending is the last one the current read phase is allowed.
    assign count_expired = (TIMEOUT_CYCLES != 0) && ((count_q + 32'd1) >= TimeoutLimit);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q            <= StIdle;
            count_q            <= 32'd0;
            avm_address        <= 1'b0;
            avm_read           <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            id_ok              <= 1'b0;
            ts_ok              <= 1'b0;
            timeout            <= 1'b0;
            captured_id        <= 32'd0;
            captured_timestamp <= 32'd0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q     <= StRdIdReq;
                        avm_read    <= 1'b1;
                        avm_address <= 1'b0;
                        busy        <= 1'b1;
                        id_ok       <= 1'b0;
                        ts_ok       <= 1'b0;
                        timeout     <= 1'b0;
                        count_q     <= 32'd0;
                    end
                end
                StRdIdReq, StRdTsReq: begin
                    count_q <= count_q + 32'd1;
                    if (count_expired) begin
                        state_q  <= StDone;
                        avm_read <= 1'b0;
                        timeout  <= 1'b1;
                        done     <= 1'b1;
                    end else if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        state_q  <= (state_q == StRdIdReq) ? StRdIdWait : StRdTsWait;
                    end
                end
                StRdIdWait: begin
                    count_q <= count_q + 32'd1;
                    // Data arriving on the expiry edge still counts as a completed read.
                    if (avm_readdatavalid) begin
                        captured_id <= avm_readdata;
                        id_ok       <= (avm_readdata == EXPECTED_ID);
                        state_q     <= StRdTsReq;
                        avm_read    <= 1'b1;
                        avm_address <= 1'b1;
                        count_q     <= 32'd0;
                    end else if (count_expired) begin
                        state_q <= StDone;
                        timeout <= 1'b1;
                        done    <= 1'b1;
                    end
                end
                StRdTsWait: begin
                    count_q <= count_q + 32'd1;
                    if (avm_readdatavalid) begin
                        captured_timestamp <= avm_readdata;
                        ts_ok              <= (avm_readdata == EXPECTED_TIMESTAMP);
                        state_q            <= StDone;
                        done               <= 1'b1;
                    end else if (count_expired) begin
                        state_q <= StDone;
                        timeout <= 1'b1;
                        done    <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_final_sysid_checker.sv
// Directed bench for final_sysid_checker: a small reactive ID-slave model plus a vector table
// of read scenarios and hand-written sequences for reset and start-handling corner cases.
module tb_final_sysid_checker;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
    logic        timeout;
    logic [31:0] captured_id;
    logic [31:0] captured_timestamp;

    final_sysid_checker #(
        .EXPECTED_ID       (32'd4919),
        .EXPECTED_TIMESTAMP(32'd1498052167),
        .TIMEOUT_CYCLES    (16)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .busy              (busy),
        .done              (done),
        .id_ok             (id_ok),
        .ts_ok             (ts_ok),
        .timeout           (timeout),
        .captured_id       (captured_id),
        .captured_timestamp(captured_timestamp)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Slave model state
    int          s_wr_cycles, s_rdv_delay, s_wr_cnt, s_pend, hold_err, n_acc;
    bit          s_ts_drop, s_in_req;
    logic        s_pend_addr, s_req_addr;
    logic [31:0] s_id_data, s_ts_data;
    logic        acc_addr[4];

    task automatic slave_cfg(input int wr_cycles, input int rdv_delay, input logic [31:0] id_data,
                             input logic [31:0] ts_data, input bit ts_drop);
        s_wr_cycles = wr_cycles;
        s_rdv_delay = rdv_delay;
        s_id_data   = id_data;
        s_ts_data   = ts_data;
        s_ts_drop   = ts_drop;
        s_wr_cnt    = 0;
        s_pend      = 0;
        s_in_req    = 1'b0;
        hold_err    = 0;
        n_acc       = 0;
    endtask

    // Called once per falling edge; sets the slave inputs for the next rising edge.
    task automatic slave_step();
        avm_readdatavalid = 1'b0;
        avm_readdata      = 32'hA5A5_A5A5;
        if (s_pend > 0) begin
            s_pend--;
            if (s_pend == 0 && !(s_pend_addr && s_ts_drop)) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = s_pend_addr ? s_ts_data : s_id_data;
            end
        end
        if (avm_read) begin
            if (!s_in_req) begin
                s_in_req   = 1'b1;
                s_req_addr = avm_address;
            end else if (avm_address !== s_req_addr) begin
                hold_err++;
            end
            if (s_wr_cnt < s_wr_cycles) begin
                avm_waitrequest = 1'b1;
                s_wr_cnt++;
            end else begin
                avm_waitrequest = 1'b0;
                s_wr_cnt        = 0;
                s_in_req        = 1'b0;
                s_pend          = s_rdv_delay;
                s_pend_addr     = avm_address;
                if (n_acc < 4) acc_addr[n_acc] = avm_address;
                n_acc++;
            end
        end else begin
            avm_waitrequest = 1'b1;
            s_in_req        = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clock);
        slave_step();
    endtask

    typedef struct {
        int          wr_cycles;
        int          rdv_delay;
        logic [31:0] id_data;
        logic [31:0] ts_data;
        bit          ts_drop;
        int          exp_done_at;
        int          exp_acc;
        bit          exp_id_ok;
        bit          exp_ts_ok;
        bit          exp_timeout;
        logic [31:0] exp_cap_id;
        logic [31:0] exp_cap_ts;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vector(input vec_t v, input int idx);
        int          done_at = -1;
        int          n_done  = 0;
        logic        busy_at_done = 1'b0, busy_after = 1'b1, read_at_done = 1'b1;
        logic [2:0]  status = 3'b000;
        logic [31:0] cid = 32'd0, cts = 32'd0;
        bit          addr_bad;
        slave_cfg(v.wr_cycles, v.rdv_delay, v.id_data, v.ts_data, v.ts_drop);
        @(negedge clock);
        start = 1'b1;
        slave_step();
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (k == 0) start = 1'b0;
            if (done) begin
                n_done++;
                if (n_done == 1) begin
                    done_at      = k;
                    busy_at_done = busy;
                    read_at_done = avm_read;
                    status       = {id_ok, ts_ok, timeout};
                    cid          = captured_id;
                    cts          = captured_timestamp;
                end
            end
            if (done_at >= 0 && k == done_at + 1) busy_after = busy;
            slave_step();
            if (done_at >= 0 && k >= done_at + 3) break;
        end
        addr_bad = (n_acc > 0 && acc_addr[0] !== 1'b0) || (n_acc > 1 && acc_addr[1] !== 1'b1);
        check($sformatf("v%0d_done_at", idx), 128'(done_at), 128'(v.exp_done_at));
        check($sformatf("v%0d_done_count", idx), 128'(n_done), 128'd1);
        check($sformatf("v%0d_status", idx), 128'(status),
              128'({v.exp_id_ok, v.exp_ts_ok, v.exp_timeout}));
        check($sformatf("v%0d_captured_id", idx), 128'(cid), 128'(v.exp_cap_id));
        check($sformatf("v%0d_captured_ts", idx), 128'(cts), 128'(v.exp_cap_ts));
        check($sformatf("v%0d_accepts", idx), 128'(n_acc), 128'(v.exp_acc));
        check($sformatf("v%0d_addr_order", idx), 128'(addr_bad), 128'd0);
        check($sformatf("v%0d_addr_hold", idx), 128'(hold_err), 128'd0);
        check($sformatf("v%0d_busy_read_at_done", idx), 128'({busy_at_done, read_at_done}),
              128'(2'b10));
        check($sformatf("v%0d_busy_after_done", idx), 128'(busy_after), 128'd0);
    endtask

    function automatic logic [127:0] all_outputs();
        return 128'({avm_read, avm_address, busy, done, id_ok, ts_ok, timeout,
                     captured_id, captured_timestamp});
    endfunction

    initial begin
        int          n_done;
        int          first_done;
        logic        busy_k5, busy_k6, read_k6;
        logic [31:0] good_ts;
        good_ts = 32'd1498052167;

        vecs[0] = '{0, 1, 32'd4919, good_ts, 1'b0, 4, 2, 1'b1, 1'b1, 1'b0, 32'd4919, good_ts};
        vecs[1] = '{0, 1, 32'd4919, 32'h1234_5678, 1'b0, 4, 2, 1'b1, 1'b0, 1'b0,
                    32'd4919, 32'h1234_5678};
        vecs[2] = '{5, 3, 32'd4919, good_ts, 1'b0, 18, 2, 1'b1, 1'b1, 1'b0, 32'd4919, good_ts};
        vecs[3] = '{0, 1, 32'h0000_BEEF, good_ts, 1'b0, 4, 2, 1'b0, 1'b1, 1'b0,
                    32'h0000_BEEF, good_ts};
        vecs[4] = '{0, 1, 32'd4919, good_ts, 1'b1, 18, 2, 1'b1, 1'b0, 1'b1, 32'd4919, good_ts};
        vecs[5] = '{100, 1, 32'd4919, good_ts, 1'b0, 16, 0, 1'b0, 1'b0, 1'b1, 32'd4919, good_ts};

        reset = 1'b1;
        start = 1'b0;
        slave_cfg(0, 1, 32'd0, 32'd0, 1'b0);
        avm_waitrequest   = 1'b1;
        avm_readdatavalid = 1'b0;
        avm_readdata      = 32'd0;
        repeat (3) tick();
        check("reset_outputs", all_outputs(), 128'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_vector(vecs[i], i);

        // Reset while waiting for ID data, then a stray readdatavalid after reset.
        slave_cfg(0, 3, 32'd4919, good_ts, 1'b0);
        @(negedge clock);
        start = 1'b1;
        slave_step();
        @(negedge clock);
        start = 1'b0;
        slave_step();
        tick();
        check("in_id_wait", 128'({avm_read, busy}), 128'(2'b01));
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        slave_step();
        check("midseq_reset_outputs", all_outputs(), 128'd0);
        tick();
        tick();
        check("stray_rdv_ignored", all_outputs(), 128'd0);

        // Start while busy is dropped; the next start clears the old flags on its edge.
        slave_cfg(0, 1, 32'd4919, good_ts, 1'b1);
        @(negedge clock);
        start = 1'b1;
        slave_step();
        n_done = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clock);
            start = (k == 1);
            slave_step();
            if (done) n_done++;
        end
        check("busy_start_ignored_dones", 128'(n_done), 128'd1);
        check("first_seq_flags", 128'({id_ok, ts_ok, timeout}), 128'(3'b101));

        slave_cfg(0, 1, 32'd4919, good_ts, 1'b0);
        @(negedge clock);
        start = 1'b1;
        slave_step();
        tick();
        check("restart_clears_flags", 128'({busy, id_ok, ts_ok, timeout}), 128'(4'b1000));
        n_done     = 0;
        first_done = -1;
        busy_k5    = 1'b1;
        busy_k6    = 1'b0;
        read_k6    = 1'b0;
        for (int k = 1; k < 16; k++) begin
            @(negedge clock);
            if (k == 7) start = 1'b0;
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = k;
            end
            if (k == 5) busy_k5 = busy;
            if (k == 6) begin
                busy_k6 = busy;
                read_k6 = avm_read;
            end
            slave_step();
        end
        check("second_seq_done_at", 128'(first_done), 128'd4);
        check("idle_cycle_busy_low", 128'(busy_k5), 128'd0);
        check("held_start_retrigger", 128'({busy_k6, read_k6}), 128'(2'b11));
        check("held_start_dones", 128'(n_done), 128'd2);
        check("final_flags", 128'({id_ok, ts_ok, timeout, busy}), 128'(4'b1100));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/final_sysid_checker.md
Name: final_sysid_checker

Overview:
- Avalon-MM read master that queries the system-ID slave at boot or on request.
- Reads word 0 (system ID), then word 1 (timestamp), and compares each against build-time expected values.
- Reports pass/fail/timeout status to the CPU-less boot logic and to the debug LEDs.
- Sits on the same interconnect as the ID slave; it is the initiator side of that control_slave interface.

Parameters:
- EXPECTED_ID, 32'd4919, expected value at word address 0.
- EXPECTED_TIMESTAMP, 32'd1498052167, expected value at word address 1.
- TIMEOUT_CYCLES, 256, maximum cycles allowed per read phase (REQ+WAIT); 0 disables the timeout.

Ports:
- clock  in  1  system clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a check sequence; sampled only in IDLE.
- avm_address  out  1  word address to the ID slave.
- avm_read  out  1  read request.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  read data qualifier.
- busy  out  1  high from the cycle after start is accepted until DONE exits.
- done  out  1  single-cycle pulse when a sequence ends.
- id_ok  out  1  captured ID equals EXPECTED_ID.
- ts_ok  out  1  captured timestamp equals EXPECTED_TIMESTAMP.
- timeout  out  1  the sequence ended by timeout.
- captured_id  out  32  last ID read.
- captured_timestamp  out  32  last timestamp read.

Behaviour:
- All outputs are registered.
- Reset values: every output is 0, captured_* are 0, FSM is in IDLE, timeout counter is 0.
- FSM states: IDLE, RD_ID_REQ, RD_ID_WAIT, RD_TS_REQ, RD_TS_WAIT, DONE.
- IDLE: on start=1 go to RD_ID_REQ. On that same edge:
  - set avm_read=1, avm_address=0, busy=1;
  - clear id_ok, ts_ok, timeout and the counter.
  - captured_* keep their old values until overwritten.
- RD_x_REQ:
  - avm_read and avm_address are held stable while avm_waitrequest=1.
  - On an edge with avm_waitrequest=0 the request is accepted: go to RD_x_WAIT and drop avm_read.
- RD_x_WAIT:
  - On an edge with avm_readdatavalid=1, capture avm_readdata into captured_x and update x_ok by a 32-bit equality compare.
  - After the ID read, go to RD_TS_REQ with avm_read=1 and avm_address=1.
  - After the timestamp read, go to DONE.
- avm_readdatavalid is ignored in IDLE, REQ and DONE. Exactly one read is outstanding at a time.
- Timeout counter:
  - Cleared on entry to each REQ state; increments every cycle in REQ/WAIT.
  - If it reaches TIMEOUT_CYCLES before the phase completes: go to DONE, set timeout=1, drop avm_read. Unread ok flags stay 0.
  - If completion and timeout occur on the same edge, completion wins.
  - With TIMEOUT_CYCLES=0 the timeout never fires.
- DONE: done=1 for exactly that cycle, then IDLE. busy=0 once in IDLE.
- Status holds in IDLE until the next accepted start.
- start while busy is ignored; it is not queued.
- start held high re-triggers a new sequence on the first IDLE cycle.
- Latency with waitrequest=0 and a 1-cycle readdatavalid:
  - start sampled at edge E0 → done high in the cycle after E4;
  - busy low after E5.
- Reset mid-sequence: on the next edge return to IDLE with avm_read=0 and all outputs cleared. A late readdatavalid after reset is ignored.

Test Plan:
- Slave returns 4919 then 1498052167 with waitrequest=0, readdatavalid 1 cycle after accept → address sequence 0 then 1, done pulse 4 cycles after start, id_ok=1, ts_ok=1, timeout=0.
- Slave returns 4919 then 0x12345678 → id_ok=1, ts_ok=0, captured_timestamp=0x12345678, done asserted once.
- waitrequest=1 for 5 cycles on each read, readdatavalid delayed 3 cycles → avm_read/avm_address held stable throughout, both ok=1, done at start+4+10+4 cycles.
- Slave never asserts readdatavalid on the timestamp read, TIMEOUT_CYCLES=16 → timeout=1, id_ok=1, ts_ok=0, avm_read=0, done 16 cycles after the RD_TS_REQ entry.
- reset asserted while in RD_ID_WAIT, followed by a stray readdatavalid → all outputs 0, FSM in IDLE, captured_id stays 0.
- start pulsed again while busy, then a second start after done → only two sequences run; the second clears the previous ok/timeout flags on its start edge.
